// File: rtl/fpu_dd192_if.sv
// Operand/result bundle for the DD192 add/subtract unit.
// No valid/ready: operands are sampled on every rising edge and the matching result appears one cycle later.
interface fpu_dd192_if #(
  parameter int FORMAT_LENGTH = 32
);
  logic [FORMAT_LENGTH-1:0] op_a;
  logic [FORMAT_LENGTH-1:0] op_b;
  logic [2:0]               operation;
  logic [FORMAT_LENGTH-1:0] result;
  logic                     overflow;
  logic                     underflow;

  modport master (
    output op_a, op_b, operation,
    input  result, overflow, underflow
  );

  modport slave (
    input  op_a, op_b, operation,
    output result, overflow, underflow
  );
endinterface

// File: rtl/fpu_dd192.sv
// binary32 add/subtract: combinational decode/align/add/normalize/round feeding one register stage.
// Subnormals are flushed to zero on input and output; NaN results are always the canonical quiet NaN.
module fpu_dd192 #(
  parameter int FORMAT_LENGTH = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  fpu_dd192_if.slave      bus
);

  localparam logic [31:0] QNAN    = 32'h7FC0_0000;
  localparam logic [2:0]  OP_ADD  = 3'b000;
  localparam logic [2:0]  OP_SUB  = 3'b001;

  function automatic logic [4:0] lzc27(input logic [26:0] v);
    lzc27 = 5'd27;
    for (int i = 0; i < 27; i++) begin
      if (v[i]) lzc27 = 5'(26 - i);
    end
  endfunction

  logic [31:0] a, b;
  logic        sa, sb;
  logic [7:0]  ea, eb;
  logic [22:0] fa, fb;
  logic        a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
  logic        op_valid;

  assign a        = bus.op_a[31:0];
  assign b        = bus.op_b[31:0];
  assign op_valid = (bus.operation == OP_ADD) || (bus.operation == OP_SUB);

  // Subtraction folds into addition by flipping B's sign here, once.
  assign sa = a[31];
  assign sb = b[31] ^ (bus.operation == OP_SUB);
  assign ea = a[30:23];
  assign eb = b[30:23];
  assign fa = a[22:0];
  assign fb = b[22:0];

  assign a_zero = (ea == 8'd0);
  assign b_zero = (eb == 8'd0);
  assign a_inf  = (ea == 8'hFF) && (fa == 23'd0);
  assign b_inf  = (eb == 8'hFF) && (fb == 23'd0);
  assign a_nan  = (ea == 8'hFF) && (fa != 23'd0);
  assign b_nan  = (eb == 8'hFF) && (fb != 23'd0);

  // ---------------------------------------------------------------------------
  // Finite path
  // ---------------------------------------------------------------------------
  logic        a_ge;
  logic        sl;
  logic [7:0]  el, es, shamt;
  logic [23:0] ml, ms;
  logic        eff_sub;
  logic [49:0] wide;
  logic [25:0] al_top;
  logic        al_sticky;
  logic [27:0] sum;
  logic [4:0]  lz;
  logic [26:0] norm;
  logic [9:0]  exp_n, exp_r;
  logic [23:0] mant;
  logic        rnd_up;
  logic [24:0] mant_r;
  logic [22:0] frac_r;
  logic [31:0] fin_result;
  logic        fin_ov, fin_uf;

  always_comb begin
    a_ge       = {ea, fa} >= {eb, fb};
    sl         = a_ge ? sa : sb;
    el         = a_ge ? ea : eb;
    es         = a_ge ? eb : ea;
    ml         = a_ge ? {1'b1, fa} : {1'b1, fb};
    ms         = a_ge ? {1'b1, fb} : {1'b1, fa};
    eff_sub    = sa ^ sb;
    shamt      = el - es;
    wide       = '0;
    al_top     = '0;
    al_sticky  = 1'b0;
    sum        = '0;
    lz         = '0;
    norm       = '0;
    exp_n      = '0;
    exp_r      = '0;
    mant       = '0;
    rnd_up     = 1'b0;
    mant_r     = '0;
    frac_r     = '0;
    fin_result = '0;
    fin_ov     = 1'b0;
    fin_uf     = 1'b0;

    // Alignment keeps 24 significand bits plus guard and round; everything
    // shifted further collapses into the sticky bit.
    if (shamt > 8'd26) begin
      al_top    = '0;
      al_sticky = 1'b1;
    end else begin
      wide      = {ms, 26'd0} >> shamt;
      al_top    = wide[49:24];
      al_sticky = |wide[23:0];
    end

    if (eff_sub) sum = {1'b0, ml, 3'b000} - {1'b0, al_top, al_sticky};
    else         sum = {1'b0, ml, 3'b000} + {1'b0, al_top, al_sticky};

    lz = lzc27(sum[26:0]);
    if (sum[27]) begin
      norm  = {sum[27:2], sum[1] | sum[0]};
      exp_n = {2'b00, el} + 10'd1;
    end else begin
      norm  = sum[26:0] << lz;
      exp_n = {2'b00, el} - {5'd0, lz};
    end

    mant   = norm[26:3];
    rnd_up = norm[2] & (norm[1] | norm[0] | norm[3]);
    mant_r = {1'b0, mant} + {24'd0, rnd_up};
    if (mant_r[24]) begin
      frac_r = mant_r[23:1];
      exp_r  = exp_n + 10'd1;
    end else begin
      frac_r = mant_r[22:0];
      exp_r  = exp_n;
    end

    // exp_r is two's complement: bit 9 set means the exponent went negative.
    if (sum == 28'd0) begin
      fin_result = 32'h0000_0000;
    end else if (!exp_r[9] && (exp_r >= 10'd255)) begin
      fin_result = {sl, 8'hFF, 23'd0};
      fin_ov     = 1'b1;
    end else if (exp_r[9] || (exp_r == 10'd0)) begin
      fin_result = {sl, 31'd0};
      fin_uf     = 1'b1;
    end else begin
      fin_result = {sl, exp_r[7:0], frac_r};
    end
  end

  // ---------------------------------------------------------------------------
  // Special-case selection and output register
  // ---------------------------------------------------------------------------
  logic [31:0] result_d, result_q;
  logic        overflow_d, overflow_q;
  logic        underflow_d, underflow_q;

  always_comb begin
    result_d    = QNAN;
    overflow_d  = 1'b0;
    underflow_d = 1'b0;
    if (op_valid) begin
      if (a_nan || b_nan) begin
        result_d = QNAN;
      end else if (a_inf && b_inf) begin
        result_d = (sa != sb) ? QNAN : {sa, 8'hFF, 23'd0};
      end else if (a_inf) begin
        result_d = {sa, 8'hFF, 23'd0};
      end else if (b_inf) begin
        result_d = {sb, 8'hFF, 23'd0};
      end else if (a_zero && b_zero) begin
        result_d = {sa & sb, 31'd0};
      end else if (a_zero) begin
        result_d = {sb, b[30:0]};
      end else if (b_zero) begin
        result_d = a;
      end else begin
        result_d    = fin_result;
        overflow_d  = fin_ov;
        underflow_d = fin_uf;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_q    <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      result_q    <= result_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign bus.result    = FORMAT_LENGTH'(result_q);
  assign bus.overflow  = overflow_q;
  assign bus.underflow = underflow_q;

endmodule

// File: tb/tb_fpu_dd192.sv
// Self-checking bench for fpu_dd192: vector table, random identity checks and a mid-stream reset sequence.
module tb_fpu_dd192;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  fpu_dd192_if #(.FORMAT_LENGTH(32)) bus ();

  fpu_dd192 #(.FORMAT_LENGTH(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  op;
    logic [31:0] res;
    logic        ov;
    logic        uf;
  } vec_t;

  vec_t        vecs[$];
  logic [33:0] exp_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;

  task automatic check(input string name, input logic [33:0] act, input logic [33:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got res=%h ov=%b uf=%b, required res=%h ov=%b uf=%b",
               name, act[31:0], act[33], act[32], req[31:0], req[33], req[32]);
    end
  endtask

  // Drive on the falling edge, record the expectation, then compare just after
  // the rising edge that captures it.
  task automatic apply(input string name, input logic [31:0] a, input logic [31:0] b,
                       input logic [2:0] op, input logic [31:0] res,
                       input logic ov, input logic uf);
    logic [33:0] req;
    @(negedge clk);
    bus.op_a      = a;
    bus.op_b      = b;
    bus.operation = op;
    exp_q.push_back({ov, uf, res});
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      check({name, "_queue"}, 34'd1, 34'd0);
    end else begin
      req = exp_q.pop_front();
      check(name, {bus.overflow, bus.underflow, bus.result}, req);
    end
  endtask

  function automatic logic [31:0] rand_normal();
    logic [7:0] e;
    e = 8'($urandom_range(1, 254));
    return {1'($urandom_range(0, 1)), e, 23'($urandom_range(0, 32'h7FFFFF))};
  endfunction

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout, required test completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] x;
    logic [31:0] y;
    logic [2:0]  rop;

    vecs.push_back('{32'h0000_0000, 32'h0000_0000, 3'b000, 32'h0000_0000, 1'b0, 1'b0});
    vecs.push_back('{32'h0000_0000, 32'h0000_0000, 3'b001, 32'h0000_0000, 1'b0, 1'b0});
    vecs.push_back('{32'h0000_0000, 32'h7F80_0000, 3'b000, 32'h7F80_0000, 1'b0, 1'b0});
    vecs.push_back('{32'h0000_0000, 32'h7F80_0000, 3'b001, 32'hFF80_0000, 1'b0, 1'b0});
    vecs.push_back('{32'h3E80_8000, 32'h7F80_0000, 3'b001, 32'hFF80_0000, 1'b0, 1'b0});
    vecs.push_back('{32'h7F80_1010, 32'h7F80_0000, 3'b000, 32'h7FC0_0000, 1'b0, 1'b0});
    vecs.push_back('{32'h7F80_0000, 32'h7F80_0000, 3'b001, 32'h7FC0_0000, 1'b0, 1'b0});
    vecs.push_back('{32'h7F80_0000, 32'h7F80_0000, 3'b000, 32'h7F80_0000, 1'b0, 1'b0});
    vecs.push_back('{32'h8000_0000, 32'h8000_0000, 3'b000, 32'h8000_0000, 1'b0, 1'b0});
    vecs.push_back('{32'h8000_0000, 32'h0000_0000, 3'b001, 32'h8000_0000, 1'b0, 1'b0});
    vecs.push_back('{32'h0000_0001, 32'h3F80_0000, 3'b000, 32'h3F80_0000, 1'b0, 1'b0});
    vecs.push_back('{32'h3F00_0000, 32'h3EB0_0000, 3'b000, 32'h3F58_0000, 1'b0, 1'b0});
    vecs.push_back('{32'h3F00_0000, 32'h3EB0_0000, 3'b001, 32'h3E20_0000, 1'b0, 1'b0});
    vecs.push_back('{32'h3EB0_0000, 32'h3F00_0000, 3'b001, 32'hBE20_0000, 1'b0, 1'b0});
    vecs.push_back('{32'h429B_0000, 32'h3C02_0000, 3'b001, 32'h429A_FBF0, 1'b0, 1'b0});
    vecs.push_back('{32'h3C02_0000, 32'h429B_0000, 3'b001, 32'hC29A_FBF0, 1'b0, 1'b0});
    vecs.push_back('{32'h3C02_0000, 32'h429B_0000, 3'b000, 32'h429B_0410, 1'b0, 1'b0});
    vecs.push_back('{32'h4120_0000, 32'h7F74_0000, 3'b000, 32'h7F74_0000, 1'b0, 1'b0});
    vecs.push_back('{32'h4120_0000, 32'h7F74_0000, 3'b001, 32'hFF74_0000, 1'b0, 1'b0});
    vecs.push_back('{32'h7F7F_FFFF, 32'h7F7F_FFFF, 3'b000, 32'h7F80_0000, 1'b1, 1'b0});
    vecs.push_back('{32'hFF7F_FFFF, 32'h7F7F_FFFF, 3'b001, 32'hFF80_0000, 1'b1, 1'b0});
    vecs.push_back('{32'h7F7F_FFFF, 32'h7F7F_FFFF, 3'b001, 32'h0000_0000, 1'b0, 1'b0});
    vecs.push_back('{32'h0080_0030, 32'h0080_0005, 3'b001, 32'h0000_0000, 1'b0, 1'b1});
    vecs.push_back('{32'h3F80_0000, 32'h3F80_0000, 3'b000, 32'h4000_0000, 1'b0, 1'b0});
    vecs.push_back('{32'h3F80_0000, 32'h3F7F_FFFF, 3'b001, 32'h3380_0000, 1'b0, 1'b0});
    // Ties to even: 2^24+1 stays at 2^24, 2^24+3 rounds up to 2^24+4.
    vecs.push_back('{32'h4B80_0000, 32'h3F80_0000, 3'b000, 32'h4B80_0000, 1'b0, 1'b0});
    vecs.push_back('{32'h4B80_0001, 32'h3F80_0000, 3'b000, 32'h4B80_0002, 1'b0, 1'b0});
    vecs.push_back('{32'h3F00_0000, 32'h3EB0_0000, 3'b010, 32'h7FC0_0000, 1'b0, 1'b0});
    vecs.push_back('{32'h3F00_0000, 32'h3EB0_0000, 3'b111, 32'h7FC0_0000, 1'b0, 1'b0});

    bus.op_a      = '0;
    bus.op_b      = '0;
    bus.operation = 3'b000;
    rst_n         = 1'b0;
    #12;
    check("reset_state", {bus.overflow, bus.underflow, bus.result}, 34'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      apply($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].op,
            vecs[i].res, vecs[i].ov, vecs[i].uf);
    end

    for (int i = 0; i < 16; i++) begin
      x = rand_normal();
      apply($sformatf("rand_cancel%0d", i), x, x, 3'b001, 32'h0000_0000, 1'b0, 1'b0);
    end
    for (int i = 0; i < 16; i++) begin
      x = rand_normal();
      y = {1'($urandom_range(0, 1)), 31'd0};
      apply($sformatf("rand_plus_zero%0d", i), x, y, 3'b000, x, 1'b0, 1'b0);
    end
    for (int i = 0; i < 16; i++) begin
      x   = $urandom();
      y   = $urandom();
      rop = 3'($urandom_range(2, 7));
      apply($sformatf("rand_reserved%0d", i), x, y, rop, 32'h7FC0_0000, 1'b0, 1'b0);
    end

    // Mid-stream reset: an overflow result is in the register when rst_n drops.
    apply("pre_reset", 32'h7F7F_FFFF, 32'h7F7F_FFFF, 3'b000, 32'h7F80_0000, 1'b1, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset", {bus.overflow, bus.underflow, bus.result}, 34'd0);
    exp_q.delete();
    @(posedge clk);
    #1;
    check("held_in_reset", {bus.overflow, bus.underflow, bus.result}, 34'd0);
    @(negedge clk);
    rst_n         = 1'b1;
    bus.op_a      = 32'h3F00_0000;
    bus.op_b      = 32'h3EB0_0000;
    bus.operation = 3'b000;
    #1;
    check("released_before_edge", {bus.overflow, bus.underflow, bus.result}, 34'd0);
    exp_q.push_back({1'b0, 1'b0, 32'h3F58_0000});
    @(posedge clk);
    #1;
    check("first_after_reset", {bus.overflow, bus.underflow, bus.result}, exp_q.pop_front());

    apply("post_reset", 32'h3F00_0000, 32'h3EB0_0000, 3'b001, 32'h3E20_0000, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
